// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM arbiter.
// Imported by the port latch and the arbiter top.
package sdram_arb_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 8;

  localparam logic REQ_HOST   = 1'b0;
  localparam logic REQ_FLOPPY = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK,
    WAIT
  } arb_state_e;

endpackage

// File: rtl/sdram_arb_port.sv
// One requester's strobe capture latch, busy flag and read-data register.
// The busy flag doubles as the pending flag seen by the arbiter.
module sdram_arb_port
  import sdram_arb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          done,
  input  logic          rdata_load,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_wdata,
  output logic          req_wr,
  output logic [DW-1:0] rdata
);

  logic          busy_q, busy_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    if (done) begin
      busy_d = 1'b0;
    end else if ((rd | wr) && !busy_q) begin
      // write wins when both strobes arrive together
      busy_d  = 1'b1;
      addr_d  = addr;
      wdata_d = wdata;
      wr_d    = wr;
    end
    if (rdata_load) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = busy_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_wr    = wr_q;
  assign rdata     = rdata_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one byte-wide SDRAM controller port
// between the host path and the floppy CPU window.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  h_rd,
  input  logic                  h_wr,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  output logic [DATA_WIDTH-1:0] h_rdata,
  output logic                  h_busy,
  input  logic                  f_rd,
  input  logic                  f_wr,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [DATA_WIDTH-1:0] f_wdata,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_busy,
  output logic                  grant
);

  arb_state_e state_q, state_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;

  logic [ADDR_WIDTH-1:0] h_req_addr, f_req_addr;
  logic [DATA_WIDTH-1:0] h_req_wdata, f_req_wdata;
  logic                  h_req_wr, f_req_wr;
  logic                  done, h_done, f_done;
  logic                  win;

  assign done   = (state_q == WAIT) && !mem_busy;
  assign h_done = done && (grant_q == REQ_HOST);
  assign f_done = done && (grant_q == REQ_FLOPPY);

  sdram_arb_port #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_host (
    .clk        (clk),
    .reset      (reset),
    .rd         (h_rd),
    .wr         (h_wr),
    .addr       (h_addr),
    .wdata      (h_wdata),
    .done       (h_done),
    .rdata_load (h_done && !h_req_wr),
    .mem_rdata  (mem_rdata),
    .busy       (h_busy),
    .req_addr   (h_req_addr),
    .req_wdata  (h_req_wdata),
    .req_wr     (h_req_wr),
    .rdata      (h_rdata)
  );

  sdram_arb_port #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_floppy (
    .clk        (clk),
    .reset      (reset),
    .rd         (f_rd),
    .wr         (f_wr),
    .addr       (f_addr),
    .wdata      (f_wdata),
    .done       (f_done),
    .rdata_load (f_done && !f_req_wr),
    .mem_rdata  (mem_rdata),
    .busy       (f_busy),
    .req_addr   (f_req_addr),
    .req_wdata  (f_req_wdata),
    .req_wr     (f_req_wr),
    .rdata      (f_rdata)
  );

  // on a tie the requester that did not own the port last time wins
  assign win = (h_busy && f_busy) ? ~grant_q : f_busy;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (h_busy || f_busy) begin
          grant_d     = win;
          mem_addr_d  = win ? f_req_addr : h_req_addr;
          mem_wdata_d = win ? f_req_wdata : h_req_wdata;
          mem_wr_d    = win ? f_req_wr : h_req_wr;
          mem_rd_d    = ~mem_wr_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = ACK;
      ACK:   state_d = WAIT;
      WAIT: begin
        if (!mem_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= REQ_FLOPPY;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign grant     = grant_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a request-level model
// with a simple latency-programmable SDRAM controller.
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          h_rd, h_wr, f_rd, f_wr;
  logic [AW-1:0] h_addr, f_addr, mem_addr;
  logic [DW-1:0] h_wdata, f_wdata, h_rdata, f_rdata;
  logic          h_busy, f_busy;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mem_busy, grant;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .h_rd      (h_rd),
    .h_wr      (h_wr),
    .h_addr    (h_addr),
    .h_wdata   (h_wdata),
    .h_rdata   (h_rdata),
    .h_busy    (h_busy),
    .f_rd      (f_rd),
    .f_wr      (f_wr),
    .f_addr    (f_addr),
    .f_wdata   (f_wdata),
    .f_rdata   (f_rdata),
    .f_busy    (f_busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy),
    .grant     (grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // request-level model
  int            cyc = 0;
  bit            out_m [2];
  logic [AW-1:0] a_m   [2];
  logic [DW-1:0] d_m   [2];
  bit            w_m   [2];
  int            acc_m [2];
  logic [DW-1:0] rd_m  [2];
  bit            last_g;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  bit            inflight, start_pend;
  int            own, lat, cnt, comp, stall;
  logic [DW-1:0] exp_rd;
  int            force_lat = -1;
  int            force_rd  = -1;
  int            n_rd = 0, n_wr = 0;
  int            txq [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      out_m[i] = 0;
      rd_m[i]  = '0;
      acc_m[i] = 0;
    end
    last_g     = 1'b1;
    m_addr     = '0;
    m_wd       = '0;
    inflight   = 0;
    start_pend = 0;
    cnt        = 0;
    comp       = 0;
    stall      = 0;
    mem_busy   = 1'b0;
  endtask

  task automatic req(input int who, input bit rd, input bit wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who == 0) begin
      h_rd = rd; h_wr = wr; h_addr = a; h_wdata = d;
    end else begin
      f_rd = rd; f_wr = wr; f_addr = a; f_wdata = d;
    end
  endtask

  task automatic tick();
    bit            acc [2];
    logic [AW-1:0] ca  [2];
    logic [DW-1:0] cd  [2];
    bit            cw  [2];
    bit            el0, el1;
    int            w;
    acc[0] = (h_rd | h_wr) && !out_m[0];
    acc[1] = (f_rd | f_wr) && !out_m[1];
    ca[0] = h_addr; cd[0] = h_wdata; cw[0] = h_wr;
    ca[1] = f_addr; cd[1] = f_wdata; cw[1] = f_wr;
    @(posedge clk);
    cyc++;
    #1;
    h_rd = 0; h_wr = 0; f_rd = 0; f_wr = 0;
    // controller: busy for lat cycles after sampling the strobe
    if (start_pend) begin
      start_pend = 0;
      cnt = lat;
      mem_busy = (cnt > 0);
      comp = cyc + ((lat + 1 > 2) ? lat + 1 : 2);
    end else if (cnt > 0) begin
      cnt--;
      mem_busy = (cnt > 0);
    end
    if (inflight && comp == cyc) begin
      if (!w_m[own]) rd_m[own] = exp_rd;
      out_m[own] = 0;
      inflight = 0;
      txq.push_back(own);
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        out_m[i] = 1; a_m[i] = ca[i]; d_m[i] = cd[i];
        w_m[i] = cw[i]; acc_m[i] = cyc;
      end
    end
    if (mem_rd || mem_wr) begin
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      check("mem_dual_strobe", {31'd0, mem_rd && mem_wr}, 0);
      check("mem_strobe_busy_ctrl", {31'd0, inflight}, 0);
      el0 = out_m[0] && acc_m[0] < cyc;
      el1 = out_m[1] && acc_m[1] < cyc;
      if (!el0 && !el1) begin
        check("mem_spurious_strobe", 1, 0);
      end else begin
        w = (el0 && el1) ? int'(!last_g) : int'(el1);
        last_g = w[0];
        check("grant_winner", {31'd0, grant}, w);
        check("mem_addr", mem_addr, a_m[w]);
        check("mem_wdata", mem_wdata, d_m[w]);
        check("mem_wr_dir", {31'd0, mem_wr}, {31'd0, w_m[w]});
        m_addr = a_m[w];
        m_wd   = d_m[w];
        own = w;
        inflight = 1;
        start_pend = 1;
        comp = 0;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        exp_rd = (force_rd >= 0) ? force_rd[7:0] : 8'($urandom);
        mem_rdata = exp_rd;
      end
    end
    check("h_busy", {31'd0, h_busy}, {31'd0, out_m[0]});
    check("f_busy", {31'd0, f_busy}, {31'd0, out_m[1]});
    check("h_rdata", h_rdata, rd_m[0]);
    check("f_rdata", f_rdata, rd_m[1]);
    check("grant_hold", {31'd0, grant}, {31'd0, last_g});
    check("mem_addr_hold", mem_addr, m_addr);
    check("mem_wdata_hold", mem_wdata, m_wd);
    if ((out_m[0] || out_m[1]) && !inflight) stall++;
    else stall = 0;
    if (stall > 4) begin
      check("arb_stall", 1, 0);
      stall = 0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (out_m[0] || out_m[1] || inflight); k++)
      tick();
    if (out_m[0] || out_m[1] || inflight) check("drain_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_h_busy"}, {31'd0, h_busy}, 0);
    check({tag, "_f_busy"}, {31'd0, f_busy}, 0);
    check({tag, "_h_rdata"}, h_rdata, 0);
    check({tag, "_f_rdata"}, f_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_rd"}, {31'd0, mem_rd}, 0);
    check({tag, "_mem_wr"}, {31'd0, mem_wr}, 0);
    check({tag, "_grant"}, {31'd0, grant}, 1);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base, r0, w0, k;
    reset = 1'b1;
    h_rd = 0; h_wr = 0; f_rd = 0; f_wr = 0;
    h_addr = '0; f_addr = '0; h_wdata = '0; f_wdata = '0;
    mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // single host read
    force_lat = 3; force_rd = 8'hA5; r0 = n_rd;
    req(0, 1, 0, 23'h012345, 8'h00);
    tick();
    drain();
    check("t1_rd_count", n_rd - r0, 1);
    check("t1_h_rdata", h_rdata, 8'hA5);
    force_lat = -1; force_rd = -1;

    // simultaneous writes right after reset
    async_reset("rst2");
    base = txq.size(); w0 = n_wr;
    req(0, 0, 1, 23'h000100, 8'h11);
    req(1, 0, 1, 23'h000200, 8'h22);
    tick();
    drain();
    check("t2_wr_count", n_wr - w0, 2);
    check("t2_first", txq[base], 0);
    check("t2_second", txq[base+1], 1);

    // ignored strobe while busy
    r0 = n_rd;
    req(1, 1, 0, 23'h00ABCD, 8'h00);
    tick();
    req(1, 1, 0, 23'h007777, 8'h00);
    tick();
    drain();
    check("t3_rd_count", n_rd - r0, 1);
    check("t3_addr_used", mem_addr, 23'h00ABCD);

    // rd and wr together: write wins
    r0 = n_rd; w0 = n_wr;
    req(0, 1, 1, 23'h003000, 8'h3C);
    tick();
    drain();
    check("t4_wr_count", n_wr - w0, 1);
    check("t4_rd_count", n_rd - r0, 0);
    check("t4_wdata", mem_wdata, 8'h3C);

    // saturation: re-strobe as soon as busy falls
    base = txq.size();
    for (k = 0; k < 400 && txq.size() < base + 8; k++) begin
      for (int i = 0; i < 2; i++)
        if (!out_m[i])
          req(i, 1'($urandom), 1'($urandom), 23'($urandom), 8'($urandom));
      tick();
    end
    drain();
    check("t5_count", {31'd0, txq.size() >= base + 8}, 1);
    for (int i = base + 1; i < base + 8 && i < txq.size(); i++)
      check("t5_alternate", txq[i], 1 - txq[i-1]);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 2) == 0)
          req(i, 1'($urandom), 1'($urandom), 23'($urandom), 8'($urandom));
      tick();
    end
    drain();

    // reset while the controller is busy in WAIT
    force_lat = 6;
    req(0, 1, 0, 23'h055555, 8'h00);
    for (k = 0; k < 50 && !(inflight && comp > 0 && cyc == comp - 3); k++)
      tick();
    check("t6_in_wait", {31'd0, mem_busy}, 1);
    async_reset("rst6");
    force_lat = -1;
    r0 = n_rd; w0 = n_wr;
    repeat (10) tick();
    check("t6_no_reissue", (n_rd - r0) + (n_wr - w0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
